// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES/SNES pad receiver: FSM state encoding and
// helpers for the first-pressed index width and its "nothing pressed" code.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOW   = 3'd2,
    ST_PULSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Widest index needed for BITS up to 16 (index 0..16 incl. NONE)
  localparam int MAX_IDXW = 5;

  function automatic int idx_width(input int bits);
    return $clog2(bits + 1);
  endfunction

  function automatic logic [MAX_IDXW-1:0] none_code(input int bits);
    return MAX_IDXW'((1 << idx_width(bits)) - 1);
  endfunction

endpackage

// File: rtl/nes_pad_channel.sv
// One controller channel: serial capture, inversion to active-high, priority
// encode of the lowest pressed button, optional NES_PAD_DEBOUNCE_EN filtering.
module nes_pad_channel
  import nes_pad_pkg::*;
#(
  parameter int  BITS = 8,
  localparam int IDXW = idx_width(BITS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_sample,
  input  logic            i_commit,
  input  logic [IDXW-1:0] i_bit_idx,
  input  logic            i_pad_data,
  output logic [BITS-1:0] o_buttons,
  output logic [IDXW-1:0] o_first_idx,
  output logic            o_accept
);

  localparam logic [IDXW-1:0] NONE = IDXW'(none_code(BITS));

  logic [BITS-1:0] r_raw;
  logic [BITS-1:0] w_raw_next;
  logic [BITS-1:0] r_buttons;
  logic [IDXW-1:0] r_first_idx;
  logic            w_accept;

  function automatic logic [IDXW-1:0] first_pressed(input logic [BITS-1:0] pressed);
    logic [IDXW-1:0] idx;
    idx = NONE;
    for (int i = BITS - 1; i >= 0; i--) begin
      if (pressed[i]) begin
        idx = IDXW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Raw frame with the bit currently being sampled already merged in
  always_comb begin
    w_raw_next = r_raw;
    for (int i = 0; i < BITS; i++) begin
      if (i_sample && (i_bit_idx == IDXW'(i))) begin
        w_raw_next[i] = i_pad_data;
      end else begin
        w_raw_next[i] = r_raw[i];
      end
    end
  end

  // Serial capture register, one bit per sample strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw <= {BITS{1'b1}};
    end else if (i_sample) begin
      r_raw <= w_raw_next;
    end else begin
      r_raw <= r_raw;
    end
  end

`ifdef NES_PAD_DEBOUNCE_EN
  logic [BITS-1:0] r_prev;

  // Previous complete raw frame, all-released after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= {BITS{1'b1}};
    end else if (i_commit) begin
      r_prev <= w_raw_next;
    end else begin
      r_prev <= r_prev;
    end
  end

  assign w_accept = (w_raw_next == r_prev);
`else
  assign w_accept = 1'b1;
`endif

  // Published button state, held between accepted frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buttons   <= {BITS{1'b0}};
      r_first_idx <= NONE;
    end else if (i_commit && w_accept) begin
      r_buttons   <= ~w_raw_next;
      r_first_idx <= first_pressed(~w_raw_next);
    end else begin
      r_buttons   <= r_buttons;
      r_first_idx <= r_first_idx;
    end
  end

  assign o_buttons   = r_buttons;
  assign o_first_idx = r_first_idx;
  assign o_accept    = w_accept;

endmodule

// File: rtl/nes_pad_receiver.sv
// Polls CHANNELS NES/SNES controllers over a shared latch/clock pair.
// Optional NES_PAD_DEBOUNCE_EN: outputs update only when consecutive frames agree.
module nes_pad_receiver
  import nes_pad_pkg::*;
#(
  parameter int  BITS     = 8,
  parameter int  CHANNELS = 1,
  parameter int  HALF     = 300,
  localparam int IDXW     = idx_width(BITS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [CHANNELS-1:0]           pad_data,
  output logic                          pad_latch,
  output logic                          pad_clk,
  output logic                          busy,
  output logic                          valid,
  output logic [CHANNELS-1:0][BITS-1:0] buttons,
  output logic [CHANNELS-1:0][IDXW-1:0] first_idx
);

  localparam int              TW         = $clog2(2 * HALF + 1);
  localparam logic [TW-1:0]   LATCH_LAST = TW'(2 * HALF - 1);
  localparam logic [TW-1:0]   HALF_LAST  = TW'(HALF - 1);
  localparam logic [IDXW-1:0] BIT_LAST   = IDXW'(BITS - 1);

  state_e              r_state;
  logic [TW-1:0]       r_tmr;
  logic [IDXW-1:0]     r_cnt;
  logic                r_pad_latch;
  logic                r_pad_clk;
  logic                r_busy;
  logic                r_valid;
  logic                w_sample;
  logic                w_commit;
  logic [CHANNELS-1:0] w_accept;

  assign w_sample = (r_state == ST_LOW) && (r_tmr == HALF_LAST);
  assign w_commit = w_sample && (r_cnt == BIT_LAST);

  // Frame timing FSM; all pad and status outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tmr       <= {TW{1'b0}};
      r_cnt       <= {IDXW{1'b0}};
      r_pad_latch <= 1'b0;
      r_pad_clk   <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_LATCH;
            r_tmr       <= {TW{1'b0}};
            r_pad_latch <= 1'b1;
            r_busy      <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LATCH: begin
          if (r_tmr == LATCH_LAST) begin
            r_state     <= ST_LOW;
            r_tmr       <= {TW{1'b0}};
            r_cnt       <= {IDXW{1'b0}};
            r_pad_latch <= 1'b0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_LOW: begin
          if (r_tmr == HALF_LAST) begin
            r_tmr <= {TW{1'b0}};
            if (r_cnt == BIT_LAST) begin
              // Outputs and valid change together on entry to DONE
              r_state <= ST_DONE;
              r_valid <= |w_accept;
            end else begin
              r_state   <= ST_PULSE;
              r_pad_clk <= 1'b1;
            end
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_PULSE: begin
          if (r_tmr == HALF_LAST) begin
            r_state   <= ST_LOW;
            r_tmr     <= {TW{1'b0}};
            r_cnt     <= r_cnt + 1'b1;
            r_pad_clk <= 1'b0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_tmr       <= {TW{1'b0}};
          r_cnt       <= {IDXW{1'b0}};
          r_pad_latch <= 1'b0;
          r_pad_clk   <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    nes_pad_channel #(
      .BITS(BITS)
    ) u_channel (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_sample   (w_sample),
      .i_commit   (w_commit),
      .i_bit_idx  (r_cnt),
      .i_pad_data (pad_data[g]),
      .o_buttons  (buttons[g]),
      .o_first_idx(first_idx[g]),
      .o_accept   (w_accept[g])
    );
  end

  assign pad_latch = r_pad_latch;
  assign pad_clk   = r_pad_clk;
  assign busy      = r_busy;
  assign valid     = r_valid;

endmodule
